// File: rtl/nonoverlap_phase_gen.sv
// rtl/nonoverlap_phase_gen.sv - two-phase non-overlapping switch clock generator with early-fall phases
module nonoverlap_phase_gen #(
  parameter int CNT_W   = 8,
  parameter int EARLY_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [CNT_W-1:0]   cfg_dead,
  input  logic [EARLY_W-1:0] cfg_early,
  output logic               phi1,
  output logic               phi2,
  output logic               phi1e,
  output logic               phi2e,
  output logic               busy,
  output logic               period_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PH1    = 3'd1,
    DEAD12 = 3'd2,
    PH2    = 3'd3,
    DEAD21 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] d_q;
  logic [CNT_W-1:0] e_q;

  logic [CNT_W-1:0] h_new;
  logic [CNT_W-1:0] d_new;
  logic [CNT_W-1:0] e_ext;
  logic [CNT_W-1:0] e_new;

  // Sanitised configuration, only latched into the shadows at a period boundary.
  always_comb begin
    h_new = (cfg_high == ZERO) ? ONE : cfg_high;
    d_new = (cfg_dead == ZERO) ? ONE : cfg_dead;
    e_ext = CNT_W'(cfg_early);
    e_new = (e_ext > (h_new - ONE)) ? (h_new - ONE) : e_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= ZERO;
      h_q         <= ONE;
      d_q         <= ONE;
      e_q         <= ZERO;
      phi1        <= 1'b0;
      phi2        <= 1'b0;
      phi1e       <= 1'b0;
      phi2e       <= 1'b0;
      busy        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      case (state)
        IDLE: begin
          phi1  <= 1'b0;
          phi2  <= 1'b0;
          phi1e <= 1'b0;
          phi2e <= 1'b0;
          busy  <= 1'b0;
          if (en) begin
            h_q   <= h_new;
            d_q   <= d_new;
            e_q   <= e_new;
            cnt   <= h_new - ONE;
            state <= PH1;
            phi1  <= 1'b1;
            phi1e <= 1'b1;
            busy  <= 1'b1;
          end
        end

        PH1: begin
          if (cnt == ZERO) begin
            state <= DEAD12;
            cnt   <= d_q - ONE;
            phi1  <= 1'b0;
            phi1e <= 1'b0;
          end else begin
            cnt   <= cnt - ONE;
            // Early phase stays high while the next cycle still lies in the first H-E cycles.
            phi1e <= (cnt > e_q);
          end
        end

        DEAD12: begin
          if (cnt == ZERO) begin
            state <= PH2;
            cnt   <= h_q - ONE;
            phi2  <= 1'b1;
            phi2e <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end

        PH2: begin
          if (cnt == ZERO) begin
            state       <= DEAD21;
            cnt         <= d_q - ONE;
            phi2        <= 1'b0;
            phi2e       <= 1'b0;
            period_done <= (d_q == ONE);
          end else begin
            cnt   <= cnt - ONE;
            phi2e <= (cnt > e_q);
          end
        end

        DEAD21: begin
          if (cnt == ZERO) begin
            if (en) begin
              h_q   <= h_new;
              d_q   <= d_new;
              e_q   <= e_new;
              cnt   <= h_new - ONE;
              state <= PH1;
              phi1  <= 1'b1;
              phi1e <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt         <= cnt - ONE;
            period_done <= (cnt == ONE);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nonoverlap_phase_gen.md
Name: nonoverlap_phase_gen

Overview:
- Generates the two-phase non-overlapping switch clocks phi1/phi2 for the switched-capacitor filter from the single system clock `clk`.
- Also generates early-fall variants phi1e/phi2e for bottom-plate sampling.
- Phase width and dead time are counter-based and programmable; all outputs are registered and glitch-free.
- Emits a per-period strobe so downstream sampling logic knows when a full phi1/phi2 cycle of the filter has completed.

Parameters:
- CNT_W, 8: width of the phase-width and dead-time configuration and internal counter.
- EARLY_W, 4: width of the early-fall configuration.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  run request; sampled only in IDLE and at the period boundary.
- cfg_high  input  CNT_W  phi active width in clk cycles; 0 is treated as 1.
- cfg_dead  input  CNT_W  non-overlap gap in clk cycles; 0 is treated as 1, so the gap is always at least 1 cycle.
- cfg_early  input  EARLY_W  cycles by which phiNe falls before phiN; clamped to H-1.
- phi1  output  1  phase-1 switch clock.
- phi2  output  1  phase-2 switch clock.
- phi1e  output  1  early-fall phase 1 (bottom-plate).
- phi2e  output  1  early-fall phase 2 (bottom-plate).
- busy  output  1  high while not in IDLE.
- period_done  output  1  1-cycle pulse in the last cycle of each full period.

Behaviour:
- One clock domain. Reset is synchronous, active-low: at an edge with rst_n=0, state<=IDLE and all outputs<=0, including mid-phase. There is no partial-phase completion on reset.
- FSM states: IDLE, PH1, DEAD12, PH2, DEAD21. A down-counter is loaded with (length-1) on state entry; the state advances at the edge where counter==0.
- Shadow registers: H=max(cfg_high,1), D=max(cfg_dead,1), E=min(cfg_early,H-1). They are captured at the IDLE->PH1 edge and at the DEAD21->PH1 edge only. cfg changes mid-period have no effect until the next boundary.
- IDLE: when en=1 at an edge, go to PH1 and set phi1<=1 and phi1e<=1 on that same edge. When en=0, stay in IDLE with all outputs 0.
- PH1: lasts H cycles with phi1=1. phi1e=1 for the first H-E cycles, then 0. Next state DEAD12.
- DEAD12: lasts D cycles with phi1=phi2=phi1e=phi2e=0. Next state PH2.
- PH2: mirror of PH1 on phi2/phi2e. Next state DEAD21.
- DEAD21: lasts D cycles, all phases 0, period_done=1 in its last cycle.
  - At the terminal edge, en=1 goes to PH1 with new shadow cfg. en=0 goes to IDLE.
- Graceful stop: deasserting en mid-period never truncates a phase or dead time. The period finishes, then the FSM goes to IDLE.
- Period = 2*(H+D) cycles.
- Invariants:
  - phi1&phi2 is never 1.
  - phiNe=1 implies phiN=1.
  - phiNe rises on the same edge as phiN.
  - Every output is a flop Q with no combinational decode on outputs.
- busy=1 in every state except IDLE, including the DEAD21 of the stopping period.
- Counter width is CNT_W. H and D are up to 2^CNT_W-1, with no wrap beyond that.

Test Plan:
- Basic run: reset, then H=4, D=1, E=1, en=1 held. Required: phi1 high 4 cycles, low gap 1, phi2 high 4, gap 1. Period 10 cycles. phi1e/phi2e high 3 cycles. period_done pulses every 10 cycles. phi1&phi2 is never 1.
- Zero/clamp cfg: cfg_high=0, cfg_dead=0, cfg_early=7. Required: H=1, D=1, E=0. phi1/phi2 each 1 cycle high, period 4. phiNe equals phiN.
- Mid-period cfg change: running with H=4, D=1; during PH2 set cfg_high=6. Required: the current period keeps 4/1/4/1, and the next PH1 is 6 cycles.
- Graceful stop: drop en during PH1 of H=3, D=2. Required: PH1, DEAD12, PH2 and DEAD21 all complete at full length, then IDLE. busy falls on the edge after the period_done cycle, and phases stay 0 after that.
- Reset mid-phase: assert rst_n=0 for 1 cycle during PH2. Required: phi2, phi2e and busy are 0 after that edge, state is IDLE. A restart with en=1 begins at PH1.
- Back-to-back boundary: en held high over 5 periods with H=2, D=3, E=1. Required: no IDLE cycle between periods, a 10-cycle period each time, and exactly one period_done per period.
